// File: rtl/prog_mem_ld.sv
// Writable program memory: registered fetch port plus a full-array byte-stream loader.
// Optional load checksum enabled by defining PROG_MEM_LD_CSUM_EN.
module prog_mem_ld #(
  parameter int unsigned          ADDR_W = 4,
  parameter int unsigned          DATA_W = 8,
  parameter logic [DATA_W-1:0]    FILL   = '0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [ADDR_W-1:0] ad,
  input  logic              rd_en,
  // fetched word; 'do' is a reserved word, hence dout
  output logic [DATA_W-1:0] dout,
  output logic              do_valid,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy,
  output logic [DATA_W-1:0] ld_csum
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   cnt, cnt_n;
  logic                wr_en;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_en   = 1'b0;
    wr_data = FILL;
    case (state)
      S_CLEAR: begin
        wr_en = 1'b1;
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) state_n = S_IDLE;
      end
      S_IDLE: begin
        if (ld_start) begin
          state_n = S_LOAD;
          cnt_n   = '0;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          wr_en   = 1'b1;
          wr_data = ld_data;
          cnt_n   = cnt + 1'b1;
          if (cnt == LAST) state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_CLEAR;
    endcase
  end

  assign busy     = (state == S_CLEAR) || (state == S_LOAD);
  assign ld_ready = (state == S_LOAD);
  assign ld_done  = (state == S_DONE);

  // Array has no reset; CLEAR rewrites every word after each reset release.
  always_ff @(posedge clk) begin
    if (wr_en) mem[cnt] <= wr_data;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      dout     <= '0;
      do_valid <= 1'b0;
    end else begin
      do_valid <= 1'b0;
      if ((state == S_IDLE) && rd_en) begin
        dout     <= mem[ad];
        do_valid <= 1'b1;
      end
    end
  end

`ifdef PROG_MEM_LD_CSUM_EN
  logic              csum_clr;
  logic              csum_add;
  logic [DATA_W-1:0] csum_q;

  assign csum_clr = (state == S_IDLE) && ld_start;
  assign csum_add = (state == S_LOAD) && ld_valid;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)      csum_q <= '0;
    else if (csum_clr) csum_q <= '0;
    else if (csum_add) csum_q <= csum_q + ld_data;
  end

  assign ld_csum = csum_q;
`else
  assign ld_csum = '0;
`endif

endmodule
